// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch stage and its instruction buffer.
package cpu_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    FETCH,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small power-of-two FIFO of fetched {pc, instr} entries; flush beats push and pop.
module instr_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_in,
  input  fetch_entry_t             data_in,
  input  logic                     pop_in,
  input  logic                     flush_in,
  output fetch_entry_t             head_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     empty_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_in && !flush_in && (count_q != '0);
  assign do_push = push_in && !flush_in && ((count_q < (AW+1)'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign head_out  = mem_q[rd_ptr_q];
  assign count_out = count_q;
  assign empty_out = (count_q == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem req/ack handshake and feeds decode from a FIFO.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        stall_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;

  fetch_entry_t head, push_entry;
  logic [CW-1:0] count, count_nxt;
  logic         empty, push, pop, accept, held;
  logic [31:0]  target;

  assign accept = req_q && imem_ack_in;
  assign held   = req_q && !imem_ack_in;
  assign target = word_align(branch_target_in);
  assign pop    = !empty && !stall_in && !branch_taken_in;
  assign push   = accept && (state_q == FETCH) && !branch_taken_in;
  assign push_entry = '{pc: pc_q, instr: imem_data_in};

  // Occupancy after this edge decides whether a fresh request fits next cycle.
  always_comb begin
    count_nxt = count;
    if (push) count_nxt = count_nxt + CW'(1);
    if (pop)  count_nxt = count_nxt - CW'(1);
    if (branch_taken_in) count_nxt = '0;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    case (state_q)
      FETCH: begin
        if (branch_taken_in) begin
          req_d = 1'b1;
          if (held) begin
            state_d = DISCARD;
            pend_d  = target;
          end else begin
            pc_d = target;
          end
        end else begin
          if (accept) pc_d = pc_q + 32'd4;
          req_d = held || (count_nxt < CW'(FIFO_DEPTH));
        end
      end
      DISCARD: begin
        if (branch_taken_in) pend_d = target;
        if (accept) begin
          state_d = FETCH;
          pc_d    = branch_taken_in ? target : pend_q;
          req_d   = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  instr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_in  (push),
    .data_in  (push_entry),
    .pop_in   (pop),
    .flush_in (branch_taken_in),
    .head_out (head),
    .count_out(count),
    .empty_out(empty)
  );

  assign imem_req_out    = req_q;
  assign imem_addr_out   = pc_q;
  assign instr_valid_out = !empty;
  assign instr_out       = empty ? NOP_INSTR : head.instr;
  assign pc_out          = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model plus directed literal checks and random traffic.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0;
  logic        br = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] tgt = '0;
  logic        req, valid;
  logic [31:0] addr, instr, pc;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_out    (req),
    .imem_addr_out   (addr),
    .imem_ack_in     (ack),
    .imem_data_in    (data),
    .branch_taken_in (br),
    .branch_target_in(tgt),
    .stall_in        (stall),
    .instr_valid_out (valid),
    .instr_out       (instr),
    .pc_out          (pc)
  );

  always #5 clk = ~clk;

  logic [63:0] mq[$];
  logic [31:0] m_pc, m_pend;
  bit          m_req, m_disc;
  int unsigned n_total = 0;
  int unsigned n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A00_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0;
    m_pend = 32'h0;
    m_req  = 1'b0;
    m_disc = 1'b0;
  endtask

  task automatic compare_all();
    chk("req", {31'b0, req}, {31'b0, m_req});
    chk("addr", addr, m_pc);
    chk("valid", {31'b0, valid}, {31'b0, (mq.size() > 0)});
    chk("instr", instr, (mq.size() > 0) ? mq[0][31:0] : NOP);
    chk("pc_out", pc, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
  endtask

  task automatic model_update(input bit a, input bit b, input logic [31:0] t, input bit s);
    bit acc;
    logic [31:0] ta;
    acc = m_req && a;
    ta  = {t[31:2], 2'b00};
    if (m_disc) begin
      if (b) m_pend = ta;
      if (acc) begin
        m_disc = 1'b0;
        m_pc   = m_pend;
        m_req  = 1'b1;
      end
    end else if (b) begin
      mq.delete();
      if (m_req && !a) begin
        m_disc = 1'b1;
        m_pend = ta;
      end else begin
        m_pc  = ta;
        m_req = 1'b1;
      end
    end else begin
      if (mq.size() > 0 && !s) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_req = (m_req && !a) || (mq.size() < DEPTH);
    end
  endtask

  // Called just after a falling edge: check, drive, clock, advance the model.
  task automatic step(input bit a, input bit b, input logic [31:0] t, input bit s);
    compare_all();
    ack   = a;
    br    = b;
    tgt   = t;
    stall = s;
    data  = mem_word(m_pc);
    @(posedge clk);
    model_update(a, b, t, s);
    @(negedge clk);
  endtask

  task automatic chk_reset_literals(input string tag);
    chk({tag, "_req"}, {31'b0, req}, 32'd0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_pc"}, pc, 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_literals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming with single-cycle ack
    step(1, 0, 0, 0);
    chk("first_req", {31'b0, req}, 32'd1);
    chk("first_addr", addr, 32'h0);
    step(1, 0, 0, 0);
    chk("first_valid", {31'b0, valid}, 32'd1);
    chk("first_pc", pc, 32'h0);
    chk("second_addr", addr, 32'h4);
    step(1, 0, 0, 0);
    chk("stream_pc4", pc, 32'h4);
    step(1, 0, 0, 0);
    chk("stream_pc8", pc, 32'h8);

    // Decode stall fills the buffer and throttles requests
    repeat (5) step(1, 0, 0, 1);
    chk("stall_req_low", {31'b0, req}, 32'd0);
    chk("stall_head", pc, 32'h8);
    step(1, 0, 0, 0);
    chk("release_pc12", pc, 32'hC);
    step(1, 0, 0, 0);
    chk("release_pc16", pc, 32'h10);

    // Redirect while a request waits for a late ack
    step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0100, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("disc_addr", addr, 32'h100);
    chk("disc_valid", {31'b0, valid}, 32'd0);
    step(1, 0, 0, 0);
    chk("disc_first_pc", pc, 32'h100);

    // Redirect coinciding with ack, unaligned target
    step(1, 1, 32'h0000_0203, 0);
    chk("coinc_addr", addr, 32'h200);
    chk("coinc_valid", {31'b0, valid}, 32'd0);
    chk("coinc_instr", instr, 32'h0000_0013);

    // PC wrap at the top of the address space
    step(1, 1, 32'hFFFF_FFFC, 0);
    chk("wrap_addr_hi", addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("wrap_addr_lo", addr, 32'h0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a discard
    step(0, 0, 0, 0);
    step(0, 1, 32'h0000_0040, 0);
    step(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_literals("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    chk("restart_addr", addr, 32'h0);
    chk("restart_req", {31'b0, req}, 32'd1);
    step(1, 0, 0, 0);
    chk("restart_pc", pc, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit a, b, s;
      logic [31:0] t;
      a = m_req && ($urandom_range(0, 3) != 0);
      b = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) == 0);
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step(a, b, t, s);
    end
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
